// File: rtl/temp_argmax_if.sv
// temp_argmax_if: bundles the buffer read port, the start/busy/done handshake
// and the classification result of temp_argmax.
//   master : the argmax engine (drives reads, handshake status and result)
//   slave  : the environment (buffer + requester)
interface temp_argmax_if #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8
) ();

  logic                  start_i;
  logic                  wr_busy_i;
  logic                  rd_temp_en_o;
  logic [ADDR_WIDTH-1:0] temp_rd_addr_o;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  clear_o;
  logic                  busy_o;
  logic                  done_o;
  logic [ADDR_WIDTH-1:0] class_o;
  logic [DATA_WIDTH-1:0] max_val_o;

  modport master (
    input  start_i, wr_busy_i, data_in,
    output rd_temp_en_o, temp_rd_addr_o, clear_o, busy_o, done_o, class_o, max_val_o
  );

  modport slave (
    output start_i, wr_busy_i, data_in,
    input  rd_temp_en_o, temp_rd_addr_o, clear_o, busy_o, done_o, class_o, max_val_o
  );

endinterface

// File: rtl/temp_argmax.sv
// temp_argmax: scans NUM_CLASS signed scores from the temporary result buffer
// and reports the index (lowest on ties) and value of the largest one.
// Optional macro TEMP_ARGMAX_CLEAR_EN adds a CLEAR state that pulses clear_o
// once the result is out, waiting for any buffer write to finish first.
// MAC_CNT must be at least 2 so the address has a non-zero width.
module temp_argmax #(
  parameter int MAC_CNT    = 128,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = $clog2(MAC_CNT),
  parameter int NUM_CLASS  = 10
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  temp_argmax_if.master bus
);

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(NUM_CLASS - 1);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
`ifdef TEMP_ARGMAX_CLEAR_EN
    , CLEAR
`endif
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic                  rd_vld_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic                  first_q;
  logic [DATA_WIDTH-1:0] max_q;
  logic [ADDR_WIDTH-1:0] cls_q;
  logic [DATA_WIDTH-1:0] max_out_q;
  logic [ADDR_WIDTH-1:0] class_out_q;

  logic rd_en;
  logic busy;
  logic done;
  logic clear;
  logic take;

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state and handshake outputs.
  // NOTE: every signal assigned here gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    rd_en   = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    clear   = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (bus.start_i) state_d = READ;
      end
      READ: begin
        // A read issued during a buffer write would be dropped, so hold off.
        rd_en = !bus.wr_busy_i;
        if (rd_en && cnt_q == LAST) state_d = DRAIN;
      end
      DRAIN: begin
        if (rd_vld_q && idx_q == LAST) state_d = DONE;
      end
      DONE: begin
        done = 1'b1;
`ifdef TEMP_ARGMAX_CLEAR_EN
        state_d = CLEAR;
`else
        state_d = IDLE;
`endif
      end
`ifdef TEMP_ARGMAX_CLEAR_EN
      CLEAR: begin
        if (!bus.wr_busy_i) begin
          clear   = 1'b1;
          state_d = IDLE;
        end
      end
`endif
      default: begin
        busy    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // A returned score replaces the running maximum if it is the first one or
  // strictly larger; ties keep the earlier (lower) index.
  always_comb begin
    take = rd_vld_q && (first_q || ($signed(bus.data_in) > $signed(max_q)));
  end

  // Address counter, read-valid pipe, running maximum and held result.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      cnt_q       <= '0;
      rd_vld_q    <= 1'b0;
      idx_q       <= '0;
      first_q     <= 1'b0;
      max_q       <= '0;
      cls_q       <= '0;
      max_out_q   <= '0;
      class_out_q <= '0;
    end else begin
      rd_vld_q <= rd_en;
      idx_q    <= cnt_q;

      if (take) begin
        max_q   <= bus.data_in;
        cls_q   <= idx_q;
        first_q <= 1'b0;
      end

      if (state_q == IDLE && bus.start_i) begin
        cnt_q   <= '0;
        first_q <= 1'b1;
      end else if (rd_en) begin
        cnt_q <= cnt_q + 1'b1;
      end

      // Publish the result including the final compare, so it is visible
      // during the DONE cycle and held until a later scan finishes.
      if (state_q == DRAIN && state_d == DONE) begin
        max_out_q   <= take ? bus.data_in : max_q;
        class_out_q <= take ? idx_q : cls_q;
      end
    end
  end

  assign bus.rd_temp_en_o   = rd_en;
  assign bus.temp_rd_addr_o = cnt_q;
  assign bus.busy_o         = busy;
  assign bus.done_o         = done;
  assign bus.clear_o        = clear;
  assign bus.class_o        = class_out_q;
  assign bus.max_val_o      = max_out_q;

endmodule

// File: tb/tb_temp_argmax.sv
// tb_temp_argmax: directed bench for temp_argmax with a one-cycle-latency
// buffer model. Cycle c is counted from the negedge where start_i is raised.
module tb_temp_argmax;

  localparam int AW = 7;
  localparam int DW = 8;
  localparam int NC = 10;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  temp_argmax_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  temp_argmax #(
    .MAC_CNT(128), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CLASS(NC)
  ) dut (
    .clk_i (clk),
    .rstn_i(rstn),
    .bus   (bus)
  );

  // Buffer model: data one cycle after the read enable, zero otherwise.
  logic [DW-1:0] mem [128];
  always @(posedge clk) bus.data_in <= bus.rd_temp_en_o ? mem[bus.temp_rd_addr_o] : '0;

  int checks   = 0;
  int failures = 0;

  // Observations from the last run_scan.
  int done_c, n_done, n_rd, clr_c, n_clr, idle_c;
  bit addr_ok;

  task automatic load_basic();
    for (int i = 0; i < 128; i++) mem[i] = '0;
    mem[0] = 8'd3;   mem[1] = 8'hFB; mem[2] = 8'd7; mem[3] = 8'd100; mem[4] = 8'd2;
    mem[5] = 8'd0;   mem[6] = 8'hFF; mem[7] = 8'd99; mem[8] = 8'd4;  mem[9] = 8'd5;
  endtask

  task automatic fill(input logic [DW-1:0] v);
    for (int i = 0; i < 128; i++) mem[i] = v;
  endtask

  // Start at c=0, optional extra starts, wr_busy_i high for c in
  // [stall_at, stall_at+stall_len). Records reads, done and clear timing.
  task automatic run_scan(input int stall_at, input int stall_len,
                          input int extra_a, input int extra_b, input int ncyc);
    int exp_addr;
    exp_addr = 0;
    n_done = 0; done_c = -1; n_rd = 0; addr_ok = 1'b1;
    clr_c = -1; n_clr = 0; idle_c = -1;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      bus.start_i   = (c == 0 || c == extra_a || c == extra_b);
      bus.wr_busy_i = (c >= stall_at && c < stall_at + stall_len);
      #1;
      if (bus.rd_temp_en_o) begin
        if (bus.wr_busy_i || bus.temp_rd_addr_o != exp_addr[AW-1:0]) addr_ok = 1'b0;
        exp_addr++;
        n_rd++;
      end
      if (bus.done_o) begin
        n_done++;
        if (done_c < 0) done_c = c;
      end
      if (bus.clear_o) begin
        n_clr++;
        if (clr_c < 0) clr_c = c;
      end
      if (done_c >= 0 && c > done_c && idle_c < 0 && !bus.busy_o) idle_c = c;
    end
    @(negedge clk);
    bus.start_i   = 1'b0;
    bus.wr_busy_i = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    bus.start_i = 1'b0;
    bus.wr_busy_i = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.busy_o, bus.done_o, bus.rd_temp_en_o, bus.clear_o} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=0000", {bus.busy_o, bus.done_o, bus.rd_temp_en_o, bus.clear_o});
    end
    checks++;
    if (bus.class_o !== '0 || bus.max_val_o !== '0) begin
      failures++;
      $display("FAIL reset_result got class=%0d max=%0d exp 0/0", bus.class_o, bus.max_val_o);
    end
    checks++;
    if (bus.temp_rd_addr_o !== '0) begin
      failures++;
      $display("FAIL reset_addr got=%0d exp=0", bus.temp_rd_addr_o);
    end
    rstn = 1'b1;
  endtask

  task automatic test_basic();
    load_basic();
    run_scan(-1, 0, -1, -1, 30);
    checks++;
    if (done_c !== 12) begin failures++; $display("FAIL basic_done_cycle got=%0d exp=12", done_c); end
    checks++;
    if (n_done !== 1) begin failures++; $display("FAIL basic_done_count got=%0d exp=1", n_done); end
    checks++;
    if (n_rd !== 10) begin failures++; $display("FAIL basic_reads got=%0d exp=10", n_rd); end
    checks++;
    if (addr_ok !== 1'b1) begin failures++; $display("FAIL basic_addr_seq got=%0d exp=1", addr_ok); end
    checks++;
    if (bus.class_o !== 7'd3) begin failures++; $display("FAIL basic_class got=%0d exp=3", bus.class_o); end
    checks++;
    if (bus.max_val_o !== 8'd100) begin failures++; $display("FAIL basic_max got=%0d exp=100", bus.max_val_o); end
    checks++;
    if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL basic_idle_busy got=%b exp=0", bus.busy_o); end
  endtask

  task automatic test_negative_tie();
    fill(8'h80);
    mem[6] = 8'hFE;
    mem[8] = 8'hFE;
    run_scan(-1, 0, -1, -1, 30);
    checks++;
    if (bus.class_o !== 7'd6) begin failures++; $display("FAIL neg_class got=%0d exp=6", bus.class_o); end
    checks++;
    if (bus.max_val_o !== 8'hFE) begin failures++; $display("FAIL neg_max got=%h exp=fe", bus.max_val_o); end
    fill(8'hF9);
    run_scan(-1, 0, -1, -1, 30);
    checks++;
    if (bus.class_o !== 7'd0) begin failures++; $display("FAIL equal_class got=%0d exp=0", bus.class_o); end
    checks++;
    if (bus.max_val_o !== 8'hF9) begin failures++; $display("FAIL equal_max got=%h exp=f9", bus.max_val_o); end
  endtask

  task automatic test_stall();
    load_basic();
    run_scan(5, 3, -1, -1, 30);
    checks++;
    if (done_c !== 15) begin failures++; $display("FAIL stall_done_cycle got=%0d exp=15", done_c); end
    checks++;
    if (n_rd !== 10) begin failures++; $display("FAIL stall_reads got=%0d exp=10", n_rd); end
    checks++;
    if (addr_ok !== 1'b1) begin failures++; $display("FAIL stall_addr_seq got=%0d exp=1", addr_ok); end
    checks++;
    if (bus.class_o !== 7'd3 || bus.max_val_o !== 8'd100) begin
      failures++;
      $display("FAIL stall_result got class=%0d max=%0d exp 3/100", bus.class_o, bus.max_val_o);
    end
  endtask

  task automatic test_reset_mid_scan();
    int dones;
    load_basic();
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      bus.start_i = (c == 0);
      if (c == 6) begin
        #1;
        checks++;
        if (bus.rd_temp_en_o !== 1'b1 || bus.temp_rd_addr_o !== 7'd5) begin
          failures++;
          $display("FAIL midrst_pre got en=%b addr=%0d exp en=1 addr=5", bus.rd_temp_en_o, bus.temp_rd_addr_o);
        end
        rstn = 1'b0;
      end
    end
    @(negedge clk);
    rstn = 1'b1;
    #1;
    checks++;
    if ({bus.busy_o, bus.done_o, bus.rd_temp_en_o, bus.clear_o, bus.class_o, bus.max_val_o, bus.temp_rd_addr_o} !== '0) begin
      failures++;
      $display("FAIL midrst_outputs got busy=%b done=%b en=%b clr=%b class=%0d max=%0d addr=%0d exp all 0",
               bus.busy_o, bus.done_o, bus.rd_temp_en_o, bus.clear_o, bus.class_o, bus.max_val_o, bus.temp_rd_addr_o);
    end
    dones = 0;
    repeat (20) begin
      @(negedge clk);
      #1;
      if (bus.done_o) dones++;
    end
    checks++;
    if (dones !== 0) begin failures++; $display("FAIL midrst_no_done got=%0d exp=0", dones); end
    run_scan(-1, 0, -1, -1, 30);
    checks++;
    if (done_c !== 12 || bus.class_o !== 7'd3 || bus.max_val_o !== 8'd100) begin
      failures++;
      $display("FAIL midrst_rescan got done=%0d class=%0d max=%0d exp 12/3/100", done_c, bus.class_o, bus.max_val_o);
    end
  endtask

  task automatic test_start_busy();
    load_basic();
    run_scan(-1, 0, 4, 12, 40);
    checks++;
    if (n_done !== 1) begin failures++; $display("FAIL busy_start_dones got=%0d exp=1", n_done); end
    checks++;
    if (done_c !== 12) begin failures++; $display("FAIL busy_start_done_cycle got=%0d exp=12", done_c); end
    checks++;
    if (n_rd !== 10) begin failures++; $display("FAIL busy_start_reads got=%0d exp=10", n_rd); end
  endtask

  task automatic test_clear();
    load_basic();
    run_scan(-1, 0, -1, -1, 25);
`ifdef TEMP_ARGMAX_CLEAR_EN
    checks++;
    if (n_clr !== 1 || clr_c !== 13) begin
      failures++;
      $display("FAIL clear_pulse got count=%0d cycle=%0d exp 1/13", n_clr, clr_c);
    end
    checks++;
    if (idle_c !== 14) begin failures++; $display("FAIL clear_idle got=%0d exp=14", idle_c); end
`else
    checks++;
    if (n_clr !== 0) begin failures++; $display("FAIL clear_absent got=%0d exp=0", n_clr); end
    checks++;
    if (idle_c !== 13) begin failures++; $display("FAIL clear_idle got=%0d exp=13", idle_c); end
`endif
    run_scan(13, 2, -1, -1, 25);
`ifdef TEMP_ARGMAX_CLEAR_EN
    checks++;
    if (n_clr !== 1 || clr_c !== 15) begin
      failures++;
      $display("FAIL clear_stall_pulse got count=%0d cycle=%0d exp 1/15", n_clr, clr_c);
    end
    checks++;
    if (idle_c !== 16) begin failures++; $display("FAIL clear_stall_idle got=%0d exp=16", idle_c); end
`else
    checks++;
    if (n_clr !== 0) begin failures++; $display("FAIL clear_stall_absent got=%0d exp=0", n_clr); end
    checks++;
    if (idle_c !== 13) begin failures++; $display("FAIL clear_stall_idle got=%0d exp=13", idle_c); end
`endif
  endtask

  initial begin
    bus.start_i   = 1'b0;
    bus.wr_busy_i = 1'b0;
    test_reset();
    test_basic();
    test_negative_tie();
    test_stall();
    test_reset_mid_scan();
    test_start_busy();
    test_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/temp_argmax.md
Name: temp_argmax

Overview:
- Downstream consumer of the per-neuron temporary result buffer. After the final layer has written its NUM_CLASS scores into that buffer, this block reads them sequentially, finds the index of the largest signed score, and reports the predicted digit.
- Drives the buffer's read-enable and read-address directly, and its clear line optionally.
- Sits between the last MAC layer and the classification result register.

Parameters:
- MAC_CNT, 128: depth of the temp buffer being read.
- DATA_WIDTH, 8: score width; two's-complement signed.
- ADDR_WIDTH, $clog2(MAC_CNT): buffer address width; also the width of the class index.
- NUM_CLASS, 10: number of entries scanned, addresses 0..NUM_CLASS-1; legal range 1..MAC_CNT.

Ports:
- clk_i, input, 1: clock.
- rstn_i, input, 1: synchronous active-low reset.
- start_i, input, 1: single-cycle request to begin a scan; ignored while busy_o=1.
- wr_busy_i, input, 1: buffer write in progress; stalls reads.
- rd_temp_en_o, output, 1: buffer read enable.
- temp_rd_addr_o, output, ADDR_WIDTH: buffer read address.
- data_in, input, DATA_WIDTH: buffer read data, valid one cycle after rd_temp_en_o.
- clear_o, output, 1: buffer clear pulse (optional feature only; tied 0 otherwise).
- busy_o, output, 1: scan in progress.
- done_o, output, 1: one-cycle pulse when the result is valid.
- class_o, output, ADDR_WIDTH: argmax index; held until the next start.
- max_val_o, output, DATA_WIDTH: winning score; held until the next start.

Behaviour:
- Reset (rstn_i=0 at a clock edge):
  - State goes to IDLE.
  - All outputs go to 0, including class_o and max_val_o.
  - The internal valid pipe and counters clear.
  - Reset mid-scan aborts the scan, with no done_o pulse.
- States: IDLE, READ, DRAIN, DONE (plus CLEAR when the optional feature is compiled in).
- IDLE:
  - busy_o=0 and rd_temp_en_o=0.
  - When start_i=1, go to READ, set the address counter to 0, set busy_o=1, and set first_q=1.
- READ:
  - rd_temp_en_o = !wr_busy_i (combinational gate on the registered request).
  - temp_rd_addr_o = counter.
  - The counter increments only on cycles where rd_temp_en_o=1.
  - After the read of address NUM_CLASS-1 is issued, go to DRAIN.
  - While wr_busy_i=1, the address is held and no read is issued. The buffer gives writes priority, so a read issued during a write would be lost.
- Valid tracking:
  - rd_vld_q <= rd_temp_en_o, and idx_q <= temp_rd_addr_o.
  - A compare happens only when rd_vld_q=1. data_in on other cycles is don't-care; the buffer outputs 0 then.
- Compare:
  - The rule is signed: if first_q is set, or $signed(data_in) > $signed(max_val), then max_val <= data_in, class <= idx_q, and first_q <= 0.
  - On a tie the current value is kept, so the lowest index wins.
  - The first element loads unconditionally, so an all-negative input works.
- DRAIN:
  - rd_temp_en_o=0.
  - Wait for the final compare (rd_vld_q=1 for the last index), then go to DONE.
- DONE:
  - done_o=1 for exactly one cycle.
  - class_o and max_val_o are updated on this cycle and held afterwards.
  - busy_o drops on the following cycle, with the state going to IDLE (or CLEAR).
- Latency with no stalls:
  - Start is sampled at edge E0.
  - Reads occur in cycles E0+1 .. E0+NUM_CLASS.
  - done_o is high in cycle E0+NUM_CLASS+2.
  - Each stall cycle adds 1.
- NUM_CLASS=1: one read, then DRAIN, then DONE. class_o=0.
- start_i while busy_o=1 is ignored. start_i in the same cycle as done_o is also ignored.

Optional Feature:
- Macro TEMP_ARGMAX_CLEAR_EN.
- Defined:
  - After DONE, enter state CLEAR.
  - clear_o=1 for one cycle, asserted only if wr_busy_i=0. Otherwise wait in CLEAR.
  - Then go to IDLE.
  - busy_o stays 1 through CLEAR.
- Not defined:
  - clear_o is constant 0.
  - DONE goes directly to IDLE.
  - The CLEAR state does not exist.

Test Plan:
- Basic scan: scores {3,-5,7,100,2,0,-1,99,4,5}, start pulse -> done_o in cycle E0+12, class_o=3, max_val_o=100. rd_temp_en_o is high exactly 10 cycles, with addresses 0..9.
- Negative inputs and tie-break: all scores -128 except index 6 and index 8, both -2 -> class_o=6, max_val_o=-2 (0xFE). Repeat with all entries equal to -7 -> class_o=0, max_val_o=-7.
- Write stall: assert wr_busy_i for 3 cycles during the read of address 4 -> no read is issued while it is high, and address 4 is re-issued afterwards. done_o arrives at E0+15, and the result matches the unstalled run.
- Reset mid-scan: rstn_i=0 for 1 cycle while the read of address 5 is in progress -> next cycle all outputs are 0 and the state is IDLE. No done_o. A new start gives a correct full scan.
- Start ignored while busy: pulse start_i at E0 and again at E0+4 -> exactly one done_o pulse. A start coincident with done_o also yields no second scan.
- With TEMP_ARGMAX_CLEAR_EN: after done_o, clear_o pulses once in the next cycle and busy_o=0 the cycle after. With wr_busy_i=1 held for 2 cycles at that point, clear_o is delayed 2 cycles.
